// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: DEPTH slots with per-slot valid bits and a valid/ready
// handshake. Bubbles collapse forward, and a bubble's control bundle always reads as zero.
module pipe_stage_elastic #(
  parameter int unsigned DATA_W = 101,
  parameter int unsigned CTRL_W = 11,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  occupancy
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  adv;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_hs, out_hs;

  // A slot may load when it is empty or when its downstream neighbour moves on.
  always_comb begin : adv_chain
    logic chain;
    chain        = !valid_q[DEPTH-1] | out_ready;
    adv          = '0;
    adv[DEPTH-1] = chain;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      chain  = !valid_q[i] | chain;
      adv[i] = chain;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_ctrl  = valid_q[DEPTH-1] ? ctrl_q[DEPTH-1] : '0;
  assign occupancy = cnt_q;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctrl_d[i] = '0;
      end
    end else begin
      if (adv[0]) begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        ctrl_d[0]  = in_valid ? in_ctrl : '0;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (adv[i]) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
          ctrl_d[i]  = valid_q[i-1] ? ctrl_q[i-1] : '0;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (in_hs && !out_hs) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (out_hs && !in_hs) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        ctrl_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: DEPTH=3 and DEPTH=1 instances share one stimulus stream and are
// compared against a queue-of-words model where each word carries its slot position.
module tb_pipe_stage_elastic;

  localparam int DW = 16;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, flush, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          ir3, ov3, ir1, ov1;
  logic [DW-1:0] od3, od1;
  logic [CW-1:0] oc3, oc1;
  logic [1:0]    occ3;
  logic [0:0]    occ1;

  int checks   = 0;
  int failures = 0;

  // Model: per instance, words ordered oldest first, each with its slot position.
  int            mcnt [2];
  int            mpos [2][4];
  logic [DW-1:0] mdat [2][4];
  logic [CW-1:0] mctl [2][4];

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov3), .out_ready(out_ready),
    .out_data(od3), .out_ctrl(oc3), .occupancy(occ3)
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_ctrl(oc1), .occupancy(occ1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int depth_of(input int m);
    return (m == 0) ? 3 : 1;
  endfunction

  // A word moves if it is not at the end, or the word ahead leaves a gap, or the word ahead moves.
  function automatic logic [3:0] mdl_moves(input int m);
    logic [3:0] mv;
    mv = '0;
    for (int k = 0; k < mcnt[m]; k++) begin
      if (k == 0) mv[k] = (mpos[m][0] < depth_of(m) - 1) || out_ready;
      else        mv[k] = (mpos[m][k-1] > mpos[m][k] + 1) || mv[k-1];
    end
    return mv;
  endfunction

  function automatic logic mdl_ready(input int m);
    logic [3:0] mv;
    mv = mdl_moves(m);
    if (flush) return 1'b0;
    if (mcnt[m] == 0) return 1'b1;
    return (mpos[m][mcnt[m]-1] > 0) || mv[mcnt[m]-1];
  endfunction

  function automatic logic mdl_ov(input int m);
    return (mcnt[m] > 0) && (mpos[m][0] == depth_of(m) - 1);
  endfunction

  task automatic mdl_edge(input int m);
    logic [3:0] mv;
    logic       acc, pop;
    mv  = mdl_moves(m);
    acc = in_valid && mdl_ready(m);
    if (flush) begin
      mcnt[m] = 0;
      return;
    end
    pop = mdl_ov(m) && out_ready;
    for (int k = 0; k < mcnt[m]; k++) if (mv[k]) mpos[m][k]++;
    if (pop) begin
      for (int k = 0; k < mcnt[m] - 1; k++) begin
        mpos[m][k] = mpos[m][k+1];
        mdat[m][k] = mdat[m][k+1];
        mctl[m][k] = mctl[m][k+1];
      end
      mcnt[m]--;
    end
    if (acc) begin
      mpos[m][mcnt[m]] = 0;
      mdat[m][mcnt[m]] = in_data;
      mctl[m][mcnt[m]] = in_ctrl;
      mcnt[m]++;
    end
  endtask

  task automatic chk_out();
    chk("out_valid_d3", 32'(ov3), 32'(mdl_ov(0)));
    chk("out_ctrl_d3", 32'(oc3), mdl_ov(0) ? 32'(mctl[0][0]) : 32'd0);
    if (mdl_ov(0)) chk("out_data_d3", 32'(od3), 32'(mdat[0][0]));
    chk("occupancy_d3", 32'(occ3), 32'(mcnt[0]));
    chk("out_valid_d1", 32'(ov1), 32'(mdl_ov(1)));
    chk("out_ctrl_d1", 32'(oc1), mdl_ov(1) ? 32'(mctl[1][0]) : 32'd0);
    if (mdl_ov(1)) chk("out_data_d1", 32'(od1), 32'(mdat[1][0]));
    chk("occupancy_d1", 32'(occ1), 32'(mcnt[1]));
  endtask

  // Called just after a falling edge: drive, check in_ready, take the edge, check outputs.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                      input logic fl, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    in_ctrl   = ic;
    flush     = fl;
    out_ready = ordy;
    #1;
    chk("in_ready_d3", 32'(ir3), 32'(mdl_ready(0)));
    chk("in_ready_d1", 32'(ir1), 32'(mdl_ready(1)));
    @(negedge clk);
    mdl_edge(0);
    mdl_edge(1);
    #1;
    chk_out();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), CW'($urandom), 1'b0, ordy);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'({ov3, ov1}), 32'd0);
    chk({tag, "_out_data"}, 32'({od3, od1}), 32'd0);
    chk({tag, "_out_ctrl"}, 32'({oc3, oc1}), 32'd0);
    chk({tag, "_occupancy"}, 32'({occ3, occ1}), 32'd0);
    chk({tag, "_in_ready"}, 32'({ir3, ir1}), 32'b11);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    mcnt[0]   = 0;
    mcnt[1]   = 0;
    #2;
    chk_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);
    #1;

    // Streaming with out_ready held high.
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), CW'($urandom), 1'b0, 1'b1);
    idle(4, 1'b1);

    // Backpressure: fill, hold for 4 cycles with a word offered, then release.
    for (int i = 1; i <= 3; i++) step(1'b1, DW'(16'h100 + i), CW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h1FF), CW'($urandom), 1'b0, 1'b0);
    idle(5, 1'b1);

    // Bubble collapse: A, two idle cycles, B, all with out_ready low.
    step(1'b1, DW'(16'hA0A0), CW'(11'h123), 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b1, DW'(16'hB0B0), CW'(11'h321), 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("bubble_occupancy_d3", 32'(occ3), 32'd2);
    idle(4, 1'b1);

    // Flush while full, with a valid all-ones control word offered.
    for (int i = 1; i <= 3; i++) step(1'b1, DW'(16'h200 + i), CW'($urandom), 1'b0, 1'b0);
    step(1'b1, DW'(16'hDEAD), CW'(11'h7FF), 1'b1, 1'b0);
    chk("flush_out_ctrl_d3", 32'(oc3), 32'd0);
    idle(4, 1'b1);

    // Reset asserted between edges mid-stream.
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(16'h300 + i), CW'($urandom), 1'b0, 1'b0);
    flush = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_state("midreset");
    reset   = 1'b0;
    mcnt[0] = 0;
    mcnt[1] = 0;
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(16'h400 + i), CW'($urandom), 1'b0, 1'b1);
    idle(4, 1'b1);

    // Control word toggling validity.
    step(1'b1, DW'(16'h0051), CW'(11'h040), 1'b0, 1'b1);
    step(1'b0, DW'(16'h0052), CW'(11'h040), 1'b0, 1'b1);
    step(1'b1, DW'(16'h0053), CW'(11'h040), 1'b0, 1'b1);
    idle(4, 1'b1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), DW'($urandom), CW'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0);
    end
    idle(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised, elastic pipeline-stage register for the pipelined MIPS datapath, intended to replace the fixed, single-depth inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data bundle and a control bundle through DEPTH register slots with per-slot valid bits, a valid/ready handshake, bubble collapsing and a synchronous flush. When a slot holds a bubble, its control fields are forced to zero, so a bubble never asserts MemWrite or RegWrite downstream.

## Interface
- DATA_W, default 101: width of the data bundle (ALU result, store data, branch target, write-back address, ...).
- CTRL_W, default 11: width of the control bundle (Jump, Branch*, MemRead, MemtoReg, MemWrite, RegWrite, ...).
- DEPTH, default 1: number of register slots, legal range 1..4.
- CNT_W, derived as clog2(DEPTH+1): width of `occupancy`.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  upstream offers a word.
- in_ready  out  1  this block accepts the word at the next falling edge.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- flush  in  1  synchronous kill of every slot (branch/jump taken).
- out_valid  out  1  slot DEPTH-1 holds a valid word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  data of slot DEPTH-1.
- out_ctrl  out  CTRL_W  control of slot DEPTH-1, gated by out_valid.
- occupancy  out  CNT_W  number of valid slots.

## Operation
- Slots are numbered 0 (input side) to DEPTH-1 (output side). Each slot holds valid[i], data[i] and ctrl[i].
- Advance rule, combinational from output to input:
  - adv[DEPTH-1] = !valid[DEPTH-1] | out_ready.
  - adv[i] = !valid[i] | adv[i+1].
- in_ready = adv[0] & !flush.
- On each falling edge with flush=0:
  - Slot i loads from slot i-1 (slot 0 loads from the input) when adv[i] is 1.
  - Otherwise slot i holds its contents.
  - The loaded valid value is in_valid for slot 0 and valid[i-1] for the others.
- Bubble collapse: a stalled upstream word moves into an empty downstream slot even while the output is blocked.
- A slot that receives a non-valid word zeroes its ctrl field. Its data field may load arbitrary values.
- out_ctrl = valid[DEPTH-1] ? ctrl[DEPTH-1] : 0.
- flush=1 at a falling edge:
  - All valid bits clear and all ctrl fields go to zero.
  - Data fields hold.
  - The input word is dropped, and no handshake completes because in_ready=0.
  - flush has priority over every load or hold.
- occupancy is the population count of valid[]. It is registered as a count updated at the same edge: +1 on an input handshake, −1 on an output handshake, unchanged when both or neither occur, 0 on flush.
- Reset (asynchronous, any time, including mid-stream):
  - All valid bits, data, ctrl and occupancy go to 0.
  - Outputs become out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
  - in_ready=1 once flush=0.
- DEPTH=1 degenerates to a single-slot register with the same handshake.

## Timing
- Latency is DEPTH falling edges from input handshake to out_valid when there is no backpressure.
- Throughput is 1 word per cycle. A full pipe with out_ready=1 accepts and emits in the same cycle.
- in_ready depends combinationally on out_ready through DEPTH AND/OR levels. This path is intentional, with no skid buffer.
- flush takes effect at the edge where it is sampled. out_valid=0 from that edge on.
- Simultaneous in and out handshakes leave occupancy unchanged.
- Full pipe with out_ready=0 gives in_ready=0. This is the only non-flush condition that stalls upstream.

## Test plan
- Stream, DEPTH=3, out_ready=1: data 1,2,3,… each cycle → out_data 1 appears 3 edges after its handshake, then one word per edge, and occupancy stays 3.
- Backpressure, DEPTH=3: fill 3 words, then out_ready=0 for 4 cycles → in_ready=0, output holds word 1, occupancy=3. On release, words 1,2,3 exit in order with no loss or duplication.
- Bubble collapse, DEPTH=3: send word A, idle 2 cycles, then B, with out_ready=0 → A sits in slot 2, B advances to slot 1, occupancy=2, in_ready=1.
- Flush with in_valid=1 and ctrl=0x7FF while full → after the edge, out_valid=0, out_ctrl=0, occupancy=0, and the dropped input never appears at the output.
- Reset asserted mid-stream between edges → outputs zero immediately, without waiting for clk. After deassert, the first word accepted is the first word out.
- DEPTH=1, ctrl=0x040 with in_valid toggling 1,0,1 → out_ctrl reads 0x040, 0, 0x040, and is never nonzero while out_valid=0.
